// File: rtl/snn_pkg.sv
// Types and frame constants shared by the SNN front-end loader and snn_core.
package snn_pkg;

  localparam int NUM_INPUT_BITS  = 784;
  localparam int LAST_INPUT_ADDR = NUM_INPUT_BITS - 1;

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    START,
    RUN
  } loader_state_t;

endpackage

// File: rtl/ram.sv
// Single-port RAM with synchronous write and registered read (read-before-write).
module ram #(
  parameter int    DATA_WIDTH = 1,
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data;
    end
    q <= mem[addr];
  end

  // Power-up contents come from INIT_FILE through the vendor memory flow; the array is never reset.
  if (INIT_FILE != "") begin : g_init_file
  end

endmodule

// File: rtl/snn_input_loader.sv
// Unpacks a frame of pixel bytes into the 1-bit input RAM, pulses start to snn_core,
// then lends the RAM read port to the core until it reports done.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int    NUM_BITS  = LAST_INPUT_ADDR + 1,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = "mem_init_files/ram_input_contents.txt"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_done,
  output logic              q_input,
  output logic              start,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);

  loader_state_t     state_q, state_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              hold_taken;
  logic              rx_bypass;
  logic              ram_we;
  logic              ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wr_addr_d  = wr_addr_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
    hold_taken = 1'b0;
    rx_bypass  = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = shift_q[0];
    ram_addr   = wr_addr_q;

    case (state_q)
      IDLE: begin
        if (hold_vld_q) begin
          hold_taken = 1'b1;
          hold_vld_d = 1'b0;
          shift_d    = hold_q;
          bit_cnt_d  = '0;
          state_d    = UNPACK;
        end else if (rx_rdy) begin
          // An empty holding register is passed straight through to the shifter.
          rx_bypass = 1'b1;
          shift_d   = rx_data;
          bit_cnt_d = '0;
          state_d   = UNPACK;
        end
      end
      UNPACK: begin
        ram_we    = 1'b1;
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (wr_addr_q != LAST_ADDR) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
        if (bit_cnt_q == 3'd7) begin
          if (wr_addr_q == LAST_ADDR) begin
            state_d = START;
          end else if (hold_vld_q) begin
            hold_taken = 1'b1;
            hold_vld_d = 1'b0;
            shift_d    = hold_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      START: begin
        ram_addr  = core_addr;
        wr_addr_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        ram_addr = core_addr;
        if (core_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte is kept only while loading and only if the holding slot is free this cycle.
    if (rx_rdy) begin
      if ((state_q == IDLE || state_q == UNPACK) && (!hold_vld_q || hold_taken)) begin
        if (!rx_bypass) begin
          hold_d     = rx_data;
          hold_vld_d = 1'b1;
        end
        if (wr_addr_q == '0) begin
          busy_d    = 1'b1;
          overrun_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  ram #(
    .DATA_WIDTH(1),
    .ADDR_WIDTH(ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .data (ram_wdata),
    .q    (ram_q)
  );

  assign q_input = (state_q == RUN) && ram_q;
  assign start   = (state_q == START);
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_snn_input_loader.sv
`timescale 1ns/1ps
// Bench for snn_input_loader: frames are modelled as a byte list mapped onto a
// 784-pixel array (byte k bit b -> pixel 8k+b) and read back through the core port.
module tb_snn_input_loader;
  import snn_pkg::*;

  localparam int NB     = NUM_INPUT_BITS;
  localparam int NBYTES = NB / 8;

  typedef struct {
    int   gap;
    logic exp_ovr;
    int   exp_acc;
  } gap_vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [9:0] core_addr = 10'd0;
  logic       core_done = 1'b0;
  logic       q_input;
  logic       start;
  logic       busy;
  logic       overrun;

  snn_input_loader #(
    .NUM_BITS (NB),
    .ADDR_W   (10),
    .INIT_FILE("mem_init_files/ram_input_contents.txt")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .core_addr(core_addr),
    .core_done(core_done),
    .q_input  (q_input),
    .start    (start),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #10 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         start_pulses = 0;
  int         p0;
  logic [7:0] acc_q [$];
  bit         exp_ram [NB];
  bit         exp_ovr;
  gap_vec_t   vecs [7];

  always @(negedge clk) begin
    if (rst_n && start) start_pulses++;
  end

  initial begin
    #10ms;
    $display("FAIL timeout: simulation did not finish, required finish within 10 ms");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    step();
    rx_rdy  = 1'b0;
  endtask

  function automatic void build_exp();
    for (int k = 0; k < NBYTES; k++)
      for (int b = 0; b < 8; b++)
        exp_ram[8*k+b] = acc_q[k][b];
  endfunction

  function automatic void fill_random();
    while (acc_q.size() < NBYTES) acc_q.push_back(8'($urandom));
  endfunction

  // Strobes acc_q[from..to-1]; gap 0 picks a random spacing of 8..16 cycles.
  task automatic send_range(input int from, input int to, input int gap, input bit glitch);
    int g;
    for (int k = from; k < to; k++) begin
      strobe(acc_q[k]);
      if (k == 0) begin
        check("first_ovr_clr", overrun, 0);
        check("first_busy", busy, 1);
        exp_ovr = 1'b0;
      end
      if (k != to - 1) begin
        g = (gap == 0) ? int'($urandom_range(16, 8)) : gap;
        for (int w = 1; w < g; w++) begin
          core_done = glitch && (k == NBYTES / 2) && (w == 1);
          step();
          core_done = 1'b0;
        end
        if (glitch && k == NBYTES / 2) check("busy_done_ignored", busy, 1);
      end
    end
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (start) seen = 1'b1;
      else step();
    end
    check("start_seen", 32'(seen), 1);
    step();
  endtask

  task automatic read_check(input bit inject, input bit rand_order);
    int a;
    for (int i = 0; i < NB; i++) begin
      a         = rand_order ? int'($urandom_range(NB - 1, 0)) : i;
      core_addr = 10'(a);
      rx_data   = 8'($urandom);
      rx_rdy    = inject && ($urandom_range(7, 0) == 0);
      if (rx_rdy) exp_ovr = 1'b1;
      step();
      rx_rdy = 1'b0;
      check($sformatf("q_input[%0d]", a), 32'(q_input), 32'(exp_ram[a]));
    end
    check("overrun_after_run", overrun, 32'(exp_ovr));
    check("busy_in_run", busy, 1);
  endtask

  task automatic done_pulse();
    core_addr = 10'd0;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("busy_after_done", busy, 0);
    check("q_after_done", q_input, 0);
    check("start_after_done", start, 0);
  endtask

  initial begin
    logic [7:0] b0, b1, b2;

    vecs = '{'{1, 1'b1, 2}, '{2, 1'b1, 2}, '{3, 1'b1, 2}, '{4, 1'b0, 3},
             '{5, 1'b0, 3}, '{8, 1'b0, 3}, '{12, 1'b0, 3}};

    // Reset state
    repeat (3) step();
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_q_input", q_input, 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Full frame of 0x01 bytes, 12 cycles apart, with exact start latency
    acc_q.delete();
    repeat (NBYTES) acc_q.push_back(8'h01);
    build_exp();
    p0 = start_pulses;
    send_range(0, NBYTES, 12, 1'b0);
    repeat (7) step();
    check("start_early", start, 0);
    step();
    check("start_latency", start, 1);
    check("busy_at_start", busy, 1);
    step();
    check("start_width", start, 0);
    read_check(1'b0, 1'b0);
    check("start_count_full", start_pulses - p0, 1);
    done_pulse();

    // Back-to-back 0xA5, 0xFF; a third byte exactly as the holding slot empties
    acc_q.delete();
    acc_q.push_back(8'hA5);
    acc_q.push_back(8'hFF);
    acc_q.push_back(8'($urandom));
    fill_random();
    build_exp();
    strobe(acc_q[0]);
    check("b2b_first_busy", busy, 1);
    exp_ovr = 1'b0;
    strobe(acc_q[1]);
    repeat (6) step();
    strobe(acc_q[2]);
    repeat (20) step();
    check("ovr_b2b", overrun, 0);
    send_range(3, NBYTES, 10, 1'b0);
    wait_start();
    read_check(1'b1, 1'b0);
    done_pulse();

    // Table: three strobes g cycles apart from IDLE
    foreach (vecs[v]) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      strobe(b0);
      check($sformatf("gap%0d_ovr_clr", vecs[v].gap), overrun, 0);
      exp_ovr = 1'b0;
      repeat (vecs[v].gap - 1) step();
      strobe(b1);
      repeat (vecs[v].gap - 1) step();
      strobe(b2);
      repeat (30) step();
      exp_ovr = vecs[v].exp_ovr;
      check($sformatf("gap%0d_overrun", vecs[v].gap), overrun, 32'(vecs[v].exp_ovr));
      acc_q.delete();
      acc_q.push_back(b0);
      acc_q.push_back(b1);
      if (vecs[v].exp_acc == 3) acc_q.push_back(b2);
      fill_random();
      build_exp();
      send_range(vecs[v].exp_acc, NBYTES, 10, 1'b0);
      wait_start();
      read_check(1'b0, 1'b0);
      check($sformatf("gap%0d_ovr_sticky", vecs[v].gap), overrun, 32'(vecs[v].exp_ovr));
      done_pulse();
    end

    // Randomized frames: random spacing, stray done, random core reads with strobes
    for (int r = 0; r < 3; r++) begin
      acc_q.delete();
      fill_random();
      build_exp();
      p0 = start_pulses;
      send_range(0, NBYTES, 0, 1'b1);
      wait_start();
      read_check(1'b1, 1'b1);
      check("start_count_rand", start_pulses - p0, 1);
      done_pulse();
    end

    // Reset mid-frame after an overrun, then a complete new frame
    acc_q.delete();
    fill_random();
    send_range(0, 40, 12, 1'b0);
    strobe(8'($urandom));
    strobe(8'($urandom));
    check("ovr_pre_reset", overrun, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_start", start, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overrun", overrun, 0);
    check("rst_mid_q_input", q_input, 0);
    repeat (2) step();
    check("rst_hold_busy", busy, 0);
    rst_n = 1'b1;
    step();
    acc_q.delete();
    fill_random();
    build_exp();
    p0 = start_pulses;
    send_range(0, NBYTES, 12, 1'b0);
    wait_start();
    read_check(1'b1, 1'b0);
    check("start_count_after_rst", start_pulses - p0, 1);
    done_pulse();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
